// File: rtl/wrldgen.sv
// wrldgen: write-strobe generator for a bank of eight load-enabled registers.
//
// A write request is accepted only in IDLE. Acceptance latches the target
// index and the data, and pulses wack. The data is then presented on dout for
// SETUP_CYC cycles before a one-cycle one-hot load strobe on ld. It stays
// stable for HOLD_CYC cycles after the strobe. stall freezes the SETUP and
// HOLD counters.
//
// Ports:
//   clk_i    in   1   clock, rising edge
//   reset_i  in   1   asynchronous active-high reset
//   wreq_i   in   1   write request, held high until wack_o
//   addr_i   in   3   target register index, sampled at acceptance
//   din_i    in  16   write data, sampled at acceptance
//   stall_i  in   1   freezes the SETUP/HOLD counters while high
//   wack_o   out  1   one-cycle acceptance pulse
//   dout_o   out 16   data to the d inputs of all target registers
//   ld_o     out  8   one-hot load strobes (bit n -> register n)
//   busy_o   out  1   high whenever the state is not IDLE
module wrldgen #(
  parameter int SETUP_CYC = 1,  // 0..3
  parameter int HOLD_CYC  = 1   // 0..3
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        wreq_i,
  input  logic [2:0]  addr_i,
  input  logic [15:0] din_i,
  input  logic        stall_i,
  output logic        wack_o,
  output logic [15:0] dout_o,
  output logic [7:0]  ld_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE, SETUP, LOAD, HOLD} state_t;

  // Counter reload values; the phase with zero cycles is skipped entirely,
  // so its reload value is never used.
  localparam logic [1:0] SETUP_INIT = 2'((SETUP_CYC > 0) ? SETUP_CYC - 1 : 0);
  localparam logic [1:0] HOLD_INIT  = 2'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

  state_t      state_q;
  logic [1:0]  cnt_q;
  logic [2:0]  areg_q;
  logic [15:0] dout_q;
  logic [7:0]  ld_q;
  logic        wack_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      areg_q  <= 3'd0;
      dout_q  <= 16'h0000;
      ld_q    <= 8'h00;
      wack_q  <= 1'b0;
    end else begin
      // Both strobes are single-cycle pulses by default.
      wack_q <= 1'b0;
      ld_q   <= 8'h00;
      case (state_q)
        IDLE: begin
          if (wreq_i) begin
            areg_q <= addr_i;
            dout_q <= din_i;
            wack_q <= 1'b1;
            if (SETUP_CYC == 0) begin
              // No setup phase: strobe straight away, using the incoming
              // index since areg_q is being loaded on this same edge.
              state_q <= LOAD;
              ld_q    <= 8'b0000_0001 << addr_i;
            end else begin
              state_q <= SETUP;
              cnt_q   <= SETUP_INIT;
            end
          end
        end
        SETUP: begin
          if (!stall_i) begin
            if (cnt_q == 2'd0) begin
              state_q <= LOAD;
              ld_q    <= 8'b0000_0001 << areg_q;
            end else begin
              cnt_q <= cnt_q - 2'd1;
            end
          end
        end
        LOAD: begin
          // LOAD always lasts exactly one cycle; stall is deliberately ignored.
          if (HOLD_CYC == 0) begin
            state_q <= IDLE;
          end else begin
            state_q <= HOLD;
            cnt_q   <= HOLD_INIT;
          end
        end
        HOLD: begin
          if (!stall_i) begin
            if (cnt_q == 2'd0) begin
              state_q <= IDLE;
            end else begin
              cnt_q <= cnt_q - 2'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wack_o = wack_q;
  assign dout_o = dout_q;
  assign ld_o   = ld_q;
  assign busy_o = (state_q != IDLE);

endmodule

// File: doc/wrldgen.md
WRLDGEN -- requirements
Module: wrldgen

Interface
REQ-001 Parameter SETUP_CYC, default 1, number of cycles (0..3) dout is stable before the load strobe.
REQ-002 Parameter HOLD_CYC, default 1, number of cycles (0..3) dout is held stable after the load strobe.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 wreq  in  1  write request; requester holds it high until wack.
REQ-006 addr  in  3  target register index, sampled at acceptance.
REQ-007 din  in  16  write data, sampled at acceptance.
REQ-008 stall  in  1  freezes the SETUP and HOLD counters while high.
REQ-009 wack  out  1  one-cycle acceptance pulse.
REQ-010 dout  out  16  data to the d inputs of all eight target load-enabled registers.
REQ-011 ld  out  8  one-hot load strobes, bit n to the ld input of register n.
REQ-012 busy  out  1  high whenever the state is not IDLE.

Function
REQ-013 The block SHALL implement the states IDLE, SETUP, LOAD and HOLD, with a 2-bit down-counter cnt for SETUP and HOLD.
REQ-014 In IDLE with wreq=1 at a clock edge, the block SHALL latch addr into areg and din into dout, and assert wack for the following cycle only.
REQ-014a At that edge, the block SHALL enter SETUP with cnt=SETUP_CYC-1, or enter LOAD directly when SETUP_CYC=0.
REQ-015 In IDLE with wreq=0, the block SHALL hold all outputs unchanged except that ld and wack are 0.
REQ-016 In SETUP, the block SHALL decrement cnt each edge with stall=0, hold cnt with stall=1, and enter LOAD on the edge where cnt=0 and stall=0.
REQ-017 LOAD SHALL last exactly one cycle regardless of stall, with ld = one-hot(areg) and all other bits 0.
REQ-018 From LOAD the block SHALL enter HOLD with cnt=HOLD_CYC-1, or enter IDLE directly when HOLD_CYC=0.
REQ-019 In HOLD, cnt SHALL behave as in SETUP (stall-frozen), and the block SHALL enter IDLE on the edge where cnt=0 and stall=0.
REQ-020 ld SHALL be a registered output, asserted for exactly one cycle per accepted write, and never with more than one bit set.
REQ-021 dout SHALL change only at an acceptance edge, and SHALL be stable through SETUP, LOAD and HOLD.
REQ-022 wreq SHALL be ignored, with no wack, whenever the state is not IDLE; a request held high is accepted on the first IDLE cycle.
REQ-023 Minimum accept-to-accept spacing SHALL be SETUP_CYC+HOLD_CYC+2 cycles with stall=0 (4 cycles at defaults).
REQ-024 wack and ld SHALL never be high in the same cycle unless SETUP_CYC=0, in which case both are high in the LOAD cycle.
REQ-025 busy SHALL be combinational from the state: 0 in IDLE, 1 otherwise.

Reset
REQ-026 reset=1 SHALL asynchronously force state=IDLE, cnt=0, areg=0, dout=16'h0000, ld=8'h00, wack=0 and busy=0.
REQ-027 Reset asserted mid-transfer, including during LOAD, SHALL drop ld to 0 immediately with no completion or partial strobe after release.
REQ-028 The first edge after reset deasserts SHALL be able to accept a pending wreq.

Verification
REQ-029 Defaults; wreq=1, addr=5, din=16'hBEEF at edge 0 -> wack high in cycle 1, ld=8'h20 in cycle 2 only, dout=16'hBEEF in cycles 1-3, busy=0 from cycle 4.
REQ-030 wreq held high continuously with alternating addr 0/7 -> ld pulses 8'h01 and 8'h80 exactly 4 cycles apart, one wack per write.
REQ-031 stall=1 for 3 cycles during SETUP -> ld is delayed 3 cycles, dout is unchanged, and no extra wack occurs.
REQ-032 SETUP_CYC=0, HOLD_CYC=0 -> wack and ld coincide in the cycle after acceptance, with 2-cycle spacing under continuous wreq.
REQ-033 Reset asserted in the LOAD cycle -> ld=0 within that cycle, all outputs at reset values, and no ld pulse after release until a new wreq.
